data_mem_ctrl: RTL and testbench

//  Two-port arbiter/sequencer in front of the byte-wide 256x8 data RAM.

---
 rtl/data_mem_ctrl_if.sv | 17 +
 rtl/data_mem_ctrl.sv | 127 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Requester-side bus of data_mem_ctrl: one instance per requester (A and B).
// The requester drives the master side; the controller sits on the slave side.
interface data_mem_ctrl_if #(
  parameter int ADDR_W = 8
) ();
  logic              req;
  logic              we;
  logic              size;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic              err;
  logic [31:0]       rdata;

  modport master (output req, we, size, addr, wdata, input ack, err, rdata);
  modport slave  (input req, we, size, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/data_mem_ctrl.sv
// Round-robin arbiter/sequencer for a byte-wide RAM shared by two requesters.
// Word accesses are split into four big-endian byte beats; one transaction in flight.
module data_mem_ctrl #(
  parameter int ADDR_W          = 8,
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  data_mem_ctrl_if.slave    a,
  data_mem_ctrl_if.slave    b,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_din,
  input  logic [7:0]        ram_dout,
  output logic              busy,
  output logic              grant
);

  typedef enum logic [1:0] {IDLE, BEAT, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q;
  logic              grant_q;
  logic              we_q;
  logic              size_q;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;
  logic [31:0]       shreg_q;
  logic [31:0]       a_rdata_q, b_rdata_q;

  logic              start, pick_b;
  logic              we_sel, size_sel;
  logic [ADDR_W-1:0] addr_sel;
  logic [31:0]       wdata_sel;
  logic              misalign;
  logic [1:0]        last;
  logic [31:0]       rd_word;
  logic              ack;

  // Both requesting: serve the port that did not own the previous transaction.
  assign start     = a.req | b.req;
  assign pick_b    = b.req & (~a.req | ~grant_q);
  assign we_sel    = pick_b ? b.we    : a.we;
  assign size_sel  = pick_b ? b.size  : a.size;
  assign addr_sel  = pick_b ? b.addr  : a.addr;
  assign wdata_sel = pick_b ? b.wdata : a.wdata;
  assign misalign  = ERR_ON_MISALIGN && size_sel && (addr_sel[1:0] != 2'b00);

  assign last    = size_q ? 2'd3 : 2'd0;
  assign rd_word = size_q ? {shreg_q[23:0], ram_dout} : {24'b0, ram_dout};

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d  = state_q;
    ram_en   = 1'b0;
    ram_rw   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    ack      = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = misalign ? DONE : BEAT;
      BEAT: begin
        ram_en   = 1'b1;
        ram_rw   = we_q;
        ram_addr = addr_q + ADDR_W'(cnt_q);
        ram_din  = shreg_q[31:24];
        if (cnt_q == last) state_d = DONE;
      end
      DONE: begin
        ack     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The shift register carries write bytes out of [31:24] and read bytes in at [7:0],
  // so after a word read it holds the big-endian assembled value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant_q   <= 1'b1;
      we_q      <= 1'b0;
      size_q    <= 1'b0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      shreg_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
      state_q <= state_d;
      case (state_q)
        IDLE: if (start) begin
          grant_q <= pick_b;
          we_q    <= we_sel;
          size_q  <= size_sel;
          addr_q  <= size_sel ? {addr_sel[ADDR_W-1:2], 2'b00} : addr_sel;
          err_q   <= misalign;
          cnt_q   <= '0;
          shreg_q <= size_sel ? wdata_sel : {wdata_sel[7:0], 24'b0};
        end
        BEAT: begin
          cnt_q   <= cnt_q + 2'd1;
          shreg_q <= {shreg_q[23:0], ram_dout};
          if (cnt_q == last && !we_q) begin
            if (grant_q) b_rdata_q <= rd_word;
            else         a_rdata_q <= rd_word;
          end
        end
        default: ;
      endcase
    end
  end

  assign a.ack   = ack & ~grant_q;
  assign b.ack   = ack &  grant_q;
  assign a.err   = a.ack & err_q;
  assign b.err   = b.ack & err_q;
  assign a.rdata = a_rdata_q;
  assign b.rdata = b_rdata_q;
  assign busy    = (state_q != IDLE);
  assign grant   = grant_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: table of single transactions plus hand-written
// sequences for arbitration, the non-rejecting misalign variant and reset mid-transaction.
module tb_data_mem_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  data_mem_ctrl_if #(.ADDR_W(8)) a_if ();
  data_mem_ctrl_if #(.ADDR_W(8)) b_if ();
  data_mem_ctrl_if #(.ADDR_W(8)) a0_if ();
  data_mem_ctrl_if #(.ADDR_W(8)) b0_if ();

  logic       ram_en, ram_rw, busy, grant;
  logic [7:0] ram_addr, ram_din, ram_dout;
  logic       ram0_en, ram0_rw, busy0, grant0;
  logic [7:0] ram0_addr, ram0_din, ram0_dout;

  logic [7:0] mem  [256];
  logic [7:0] mem0 [256];

  data_mem_ctrl #(.ADDR_W(8), .ERR_ON_MISALIGN(1'b1)) u_dut (
    .clk(clk), .reset_n(reset_n), .a(a_if), .b(b_if),
    .ram_en(ram_en), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy), .grant(grant)
  );

  data_mem_ctrl #(.ADDR_W(8), .ERR_ON_MISALIGN(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .a(a0_if), .b(b0_if),
    .ram_en(ram0_en), .ram_rw(ram0_rw), .ram_addr(ram0_addr), .ram_din(ram0_din),
    .ram_dout(ram0_dout), .busy(busy0), .grant(grant0)
  );

  assign ram_dout  = mem[ram_addr];
  assign ram0_dout = mem0[ram0_addr];

  always @(posedge clk) begin
    if (ram_en && ram_rw)   mem[ram_addr]   <= ram_din;
    if (ram0_en && ram0_rw) mem0[ram0_addr] <= ram0_din;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [7:0] beat_addr [4];
  logic [7:0] beat_din  [4];

  // sel: 0 = A on u_dut, 1 = B on u_dut, 2 = B on u_dut0
  task automatic issue(input int sel, input bit we, input bit size, input logic [7:0] addr,
                       input logic [31:0] wdata, output int lat, output int beats,
                       output bit err, output logic [31:0] rd);
    bit got;
    logic en, ack;
    @(negedge clk);
    case (sel)
      0:       begin a_if.we = we;  a_if.size = size;  a_if.addr = addr;  a_if.wdata = wdata;  a_if.req = 1'b1;  end
      1:       begin b_if.we = we;  b_if.size = size;  b_if.addr = addr;  b_if.wdata = wdata;  b_if.req = 1'b1;  end
      default: begin b0_if.we = we; b0_if.size = size; b0_if.addr = addr; b0_if.wdata = wdata; b0_if.req = 1'b1; end
    endcase
    lat = 0; beats = 0; got = 1'b0; err = 1'b0; rd = '0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      en = (sel == 2) ? ram0_en : ram_en;
      if (en) begin
        if (beats < 4) begin
          beat_addr[beats] = (sel == 2) ? ram0_addr : ram_addr;
          beat_din[beats]  = (sel == 2) ? ram0_din  : ram_din;
        end
        beats++;
      end
      case (sel)
        0:       begin ack = a_if.ack;  if (ack) begin err = a_if.err;  rd = a_if.rdata;  end end
        1:       begin ack = b_if.ack;  if (ack) begin err = b_if.err;  rd = b_if.rdata;  end end
        default: begin ack = b0_if.ack; if (ack) begin err = b0_if.err; rd = b0_if.rdata; end end
      endcase
      got = ack;
    end
    a_if.req = 1'b0; b_if.req = 1'b0; b0_if.req = 1'b0;
    if (!got) lat = -1;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    bit          size;
    logic [7:0]  addr;
    logic [31:0] wdata;
    bit          exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    int          exp_beats;
  } vec_t;

  vec_t        vecs [10];
  logic [31:0] exp_a_rd, exp_b_rd;
  int          lat, beats;
  bit          err;
  logic [31:0] rd;

  initial begin
    a_if.req = 0;  a_if.we = 0;  a_if.size = 0;  a_if.addr = '0;  a_if.wdata = '0;
    b_if.req = 0;  b_if.we = 0;  b_if.size = 0;  b_if.addr = '0;  b_if.wdata = '0;
    a0_if.req = 0; a0_if.we = 0; a0_if.size = 0; a0_if.addr = '0; a0_if.wdata = '0;
    b0_if.req = 0; b0_if.we = 0; b0_if.size = 0; b0_if.addr = '0; b0_if.wdata = '0;
    for (int i = 0; i < 256; i++) begin mem[i] = 8'h00; mem0[i] = 8'h00; end
    mem[8'h00] = 8'h5A; mem[8'h01] = 8'h3C;
    mem0[8'h10] = 8'hC0; mem0[8'h11] = 8'hFF; mem0[8'h12] = 8'hEE; mem0[8'h13] = 8'h11;

    //              port we sz addr    wdata          err exp_rd         lat beats
    vecs[0] = '{1'b0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0, 32'h00000000, 5, 4};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 8'h10, 32'h00000000, 1'b0, 32'hDEADBEEF, 5, 4};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h12, 32'h00000000, 1'b0, 32'h000000BE, 2, 1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h13, 32'h00000000, 1'b1, 32'h00000000, 1, 0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 8'hFC, 32'h01020304, 1'b0, 32'h00000000, 5, 4};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 8'hFC, 32'h00000000, 1'b0, 32'h01020304, 5, 4};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 8'h20, 32'h123456A5, 1'b0, 32'h00000000, 2, 1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h20, 32'h00000000, 1'b0, 32'h000000A5, 2, 1};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 8'h21, 32'hCAFEF00D, 1'b1, 32'h00000000, 1, 0};
    vecs[9] = '{1'b1, 1'b0, 1'b0, 8'hFF, 32'h00000000, 1'b0, 32'h00000004, 2, 1};

    // Reset values
    repeat (2) @(negedge clk);
    check("reset busy",   32'(busy),   32'h0);
    check("reset grant",  32'(grant),  32'h1);
    check("reset ram_en", 32'(ram_en), 32'h0);
    check("reset a_ack",  32'(a_if.ack), 32'h0);
    check("reset a_rdata", a_if.rdata, 32'h0);
    check("reset b_rdata", b_if.rdata, 32'h0);

    // Both requesters held from reset: A first, then strict alternation
    a_if.size = 0; a_if.we = 0; a_if.addr = 8'h00; a_if.req = 1'b1;
    b_if.size = 0; b_if.we = 0; b_if.addr = 8'h01; b_if.req = 1'b1;
    reset_n = 1'b1;
    begin
      int n_ack = 0;
      for (int cyc = 0; cyc < 60 && n_ack < 4; cyc++) begin
        @(negedge clk);
        if (a_if.ack || b_if.ack) begin
          check($sformatf("rr order %0d", n_ack), 32'(b_if.ack), 32'(n_ack % 2));
          if (a_if.ack) check("rr a_rdata", a_if.rdata, 32'h5A);
          else          check("rr b_rdata", b_if.rdata, 32'h3C);
          n_ack++;
        end
      end
      a_if.req = 1'b0; b_if.req = 1'b0;
      check("rr ack count", 32'(n_ack), 32'd4);
    end
    exp_a_rd = 32'h5A;
    exp_b_rd = 32'h3C;

    // Single-transaction table
    foreach (vecs[i]) begin
      issue(int'(vecs[i].port), vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
            lat, beats, err, rd);
      check($sformatf("v%0d latency", i), 32'(lat),   32'(vecs[i].exp_lat));
      check($sformatf("v%0d beats", i),   32'(beats), 32'(vecs[i].exp_beats));
      check($sformatf("v%0d err", i),     32'(err),   32'(vecs[i].exp_err));
      check($sformatf("v%0d grant", i),   32'(grant), 32'(vecs[i].port));
      if (!vecs[i].we && !vecs[i].exp_err) begin
        if (vecs[i].port) exp_b_rd = vecs[i].exp_rd;
        else              exp_a_rd = vecs[i].exp_rd;
        check($sformatf("v%0d rdata at ack", i), rd, vecs[i].exp_rd);
      end
      check($sformatf("v%0d a_rdata", i), a_if.rdata, exp_a_rd);
      check($sformatf("v%0d b_rdata", i), b_if.rdata, exp_b_rd);
      for (int k = 0; k < vecs[i].exp_beats && k < beats && k < 4; k++) begin
        check($sformatf("v%0d beat%0d addr", i, k), 32'(beat_addr[k]), 32'(vecs[i].addr + 8'(k)));
        if (vecs[i].we)
          check($sformatf("v%0d beat%0d din", i, k), 32'(beat_din[k]),
                vecs[i].size ? 32'(8'(vecs[i].wdata >> (8 * (3 - k)))) : 32'(vecs[i].wdata[7:0]));
      end
    end
    @(negedge clk);
    check("mem 10..13", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hDEADBEEF);
    check("mem FC..FF", {mem[8'hFC], mem[8'hFD], mem[8'hFE], mem[8'hFF]}, 32'h01020304);
    check("mem 00 no wrap", 32'(mem[8'h00]), 32'h5A);
    check("mem 21 untouched", 32'(mem[8'h21]), 32'h00);

    // Misaligned word read with addr[1:0] forced to zero
    issue(2, 1'b0, 1'b1, 8'h13, 32'h0, lat, beats, err, rd);
    check("nomis latency", 32'(lat),   32'd5);
    check("nomis beats",   32'(beats), 32'd4);
    check("nomis err",     32'(err),   32'h0);
    check("nomis rdata",   rd,         32'hC0FFEE11);
    check("nomis first addr", 32'(beat_addr[0]), 32'h10);
    check("nomis last addr",  32'(beat_addr[3]), 32'h13);

    // Reset during beat 2 of a word write
    @(negedge clk);
    a_if.we = 1; a_if.size = 1; a_if.addr = 8'h40; a_if.wdata = 32'h11223344; a_if.req = 1'b1;
    repeat (3) @(negedge clk);
    check("mid beat2 addr", 32'(ram_addr), 32'h42);
    reset_n = 1'b0;
    #1;
    check("mid ram_en", 32'(ram_en), 32'h0);
    check("mid busy",   32'(busy),   32'h0);
    check("mid a_ack",  32'(a_if.ack), 32'h0);
    a_if.we = 0; a_if.size = 0; a_if.addr = 8'h40;
    b_if.we = 0; b_if.size = 0; b_if.addr = 8'h41; b_if.req = 1'b1;
    repeat (2) @(negedge clk);
    check("mid bytes written", {mem[8'h40], mem[8'h41], mem[8'h42]}, 32'h00112200);
    reset_n = 1'b1;
    begin
      bit seen = 1'b0;
      for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
        @(negedge clk);
        if (a_if.ack || b_if.ack) begin
          seen = 1'b1;
          check("post-reset first owner", 32'(b_if.ack), 32'h0);
          check("post-reset a_rdata", a_if.rdata, 32'h11);
        end
      end
      a_if.req = 1'b0; b_if.req = 1'b0;
      check("post-reset ack seen", 32'(seen), 32'h1);
    end
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
